add8_arbiter: RTL and testbench

ADD8_ARBITER -- requirements
Module: add8_arbiter

---
 rtl/add8_arbiter.sv | 113 +++++++++++
 tb/tb_add8_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/add8_arbiter.sv
// Two-requester 8-bit adder front end: arbitrates operand pairs onto one shared
// ripple adder and holds each result in a single-entry output register.

module add8_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add8_ripple #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry_out
);
    logic [W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        add8_full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign carry_out = c[W];
endmodule

module add8_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       res_valid,
    output logic       res_id,
    output logic [7:0] res_sum,
    output logic       res_carry,
    input  logic       res_ready
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic       id;
        logic       carry;
        logic [7:0] sum;
    } res_t;

    state_t     state;
    res_t       res_q;
    logic       last_grant;
    logic       slot_free;
    logic       grant1;
    logic       xfer;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] add_sum;
    logic       add_carry;

    // Output slot can take a new result if empty or being drained this cycle.
    assign slot_free  = !rst && ((state == IDLE) || res_ready);
    assign grant1     = req1_valid && (!req0_valid || (RR && !last_grant));
    assign req0_ready = slot_free && req0_valid && !grant1;
    assign req1_ready = slot_free && grant1;
    assign xfer       = req0_ready || req1_ready;

    assign op_a = grant1 ? req1_a : req0_a;
    assign op_b = grant1 ? req1_b : req0_b;

    add8_ripple #(.W(8)) u_add (
        .a         (op_a),
        .b         (op_b),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            res_q      <= '0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            state      <= HOLD;
            res_q      <= '{id: grant1, carry: add_carry, sum: add_sum};
            last_grant <= grant1;
        end else if ((state == HOLD) && res_ready) begin
            state <= IDLE;
        end
    end

    assign res_valid = (state == HOLD);
    assign res_id    = res_q.id;
    assign res_sum   = res_q.sum;
    assign res_carry = res_q.carry;
endmodule

// File: tb/tb_add8_arbiter.sv
// Bench for add8_arbiter: vector table plus hand sequences, checked against a
// small reference model with a result scoreboard.

module tb_add8_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, res_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready, res_valid, res_id, res_carry;
    logic [7:0] res_sum;
    logic       fp_req0_ready, fp_req1_ready, fp_res_valid, fp_res_id, fp_res_carry;
    logic [7:0] fp_res_sum;

    always #5 clk = ~clk;

    add8_arbiter #(.RR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .res_carry(res_carry),
        .res_ready(res_ready)
    );

    add8_arbiter #(.RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(fp_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(fp_req1_ready),
        .res_valid(fp_res_valid), .res_id(fp_res_id), .res_sum(fp_res_sum), .res_carry(fp_res_carry),
        .res_ready(res_ready)
    );

    typedef struct packed {
        logic       id;
        logic       carry;
        logic [7:0] sum;
    } res_t;

    typedef struct {
        bit         v0;
        logic [7:0] a0, b0;
        bit         v1;
        logic [7:0] a1, b1;
        bit         x0, x1;
        bit         xid;
        logic [7:0] xsum;
        bit         xc;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t sb[$];
    bit   m_hold = 1'b0;
    bit   m_last = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, advance it.
    task automatic step(input bit v0, input logic [7:0] a0, input logic [7:0] b0,
                        input bit v1, input logic [7:0] a1, input logic [7:0] b1,
                        input bit rdy, input bit r,
                        output bit o0, output bit o1, output bit f0, output bit f1);
        bit         slot, g1, e0, e1;
        logic [8:0] s;
        res_t       e;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready = rdy; rst = r;
        #1;
        slot = !r && (!m_hold || rdy);
        g1   = v1 && (!v0 || !m_last);
        e0   = slot && v0 && !g1;
        e1   = slot && g1;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("res_valid", res_valid, m_hold);
        if (m_hold && sb.size() > 0) begin
            chk("sb_res_id", res_id, sb[0].id);
            chk("sb_res_sum", res_sum, sb[0].sum);
            chk("sb_res_carry", res_carry, sb[0].carry);
        end
        o0 = req0_ready; o1 = req1_ready; f0 = fp_req0_ready; f1 = fp_req1_ready;
        if (m_hold && rdy && sb.size() > 0) void'(sb.pop_front());
        if (e0 || e1) begin
            s = g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            e.id = g1; e.sum = s[7:0]; e.carry = s[8];
            sb.push_back(e);
            m_last = g1;
        end
        m_hold = (e0 || e1) || (m_hold && !rdy);
        if (r) begin
            sb.delete();
            m_hold = 1'b0;
            m_last = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[7];
        bit   o0, o1, f0, f1;
        bit   exp_g[4];

        tbl[0] = '{1, 8'hB2, 8'h0F, 0, 8'h00, 8'h00, 1, 0, 0, 8'hC1, 0};
        tbl[1] = '{0, 8'h00, 8'h00, 1, 8'hFF, 8'h01, 0, 1, 1, 8'h00, 1};
        tbl[2] = '{0, 8'h00, 8'h00, 1, 8'd19, 8'd14, 0, 1, 1, 8'd33, 0};
        tbl[3] = '{1, 8'h10, 8'h20, 1, 8'h80, 8'h80, 1, 0, 0, 8'h30, 0};
        tbl[4] = '{1, 8'h01, 8'h01, 1, 8'h80, 8'h80, 0, 1, 1, 8'h00, 1};
        tbl[5] = '{1, 8'hFF, 8'hFF, 0, 8'hAA, 8'h55, 1, 0, 0, 8'hFE, 1};
        tbl[6] = '{1, 8'h7F, 8'h01, 0, 8'h00, 8'h00, 1, 0, 0, 8'h80, 0};
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;

        // Reset with both requesters valid: no ready, cleared outputs.
        rst = 1; res_ready = 1;
        req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34;
        req1_valid = 1; req1_a = 8'h56; req1_b = 8'h78;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_fp_req0_ready", fp_req0_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_carry", res_carry, 0);
        chk("rst_res_id", res_id, 0);

        // Vector table, back-to-back with the consumer always ready.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1,
                 1, 0, o0, o1, f0, f1);
            chk($sformatf("tbl%0d_req0_ready", i), o0, tbl[i].x0);
            chk($sformatf("tbl%0d_req1_ready", i), o1, tbl[i].x1);
            chk($sformatf("tbl%0d_res_valid", i), res_valid, 1);
            chk($sformatf("tbl%0d_res_id", i), res_id, tbl[i].xid);
            chk($sformatf("tbl%0d_res_sum", i), res_sum, tbl[i].xsum);
            chk($sformatf("tbl%0d_res_carry", i), res_carry, tbl[i].xc);
        end

        // Round-robin vs fixed priority, both requesters valid every cycle.
        step(1, 8'h11, 8'h22, 1, 8'h40, 8'hC0, 1, 1, o0, o1, f0, f1);
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h11, 8'h22, 1, 8'h40, 8'hC0, 1, 0, o0, o1, f0, f1);
            chk($sformatf("rr%0d_grant1", i), o1, exp_g[i]);
            chk($sformatf("rr%0d_grant0", i), o0, !exp_g[i]);
            chk($sformatf("fp%0d_req0_ready", i), f0, 1);
            chk($sformatf("fp%0d_req1_ready", i), f1, 0);
            chk($sformatf("rr%0d_res_id", i), res_id, exp_g[i]);
            chk($sformatf("fp%0d_res_id", i), fp_res_id, 0);
        end

        // Backpressure: result from requester 1 held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h11, 8'h22, 1, 8'h40, 8'hC0, 0, 0, o0, o1, f0, f1);
            chk($sformatf("bp%0d_req0_ready", i), o0, 0);
            chk($sformatf("bp%0d_req1_ready", i), o1, 0);
            chk($sformatf("bp%0d_res_id", i), res_id, 1);
            chk($sformatf("bp%0d_res_sum", i), res_sum, 8'h00);
            chk($sformatf("bp%0d_res_carry", i), res_carry, 1);
        end
        step(1, 8'h11, 8'h22, 1, 8'h40, 8'hC0, 1, 0, o0, o1, f0, f1);
        chk("bp_accept_req0", o0, 1);
        chk("bp_accept_res_sum", res_sum, 8'h33);

        // Reset while holding a result with both requesters pending.
        step(1, 8'h11, 8'h22, 1, 8'h40, 8'hC0, 0, 1, o0, o1, f0, f1);
        chk("midrst_req0_ready", o0, 0);
        chk("midrst_req1_ready", o1, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_sum", res_sum, 0);
        chk("midrst_res_carry", res_carry, 0);
        chk("midrst_res_id", res_id, 0);
        step(1, 8'h05, 8'h06, 1, 8'h07, 8'h08, 1, 0, o0, o1, f0, f1);
        chk("tie_after_rst_req0", o0, 1);
        chk("tie_after_rst_req1", o1, 0);
        chk("tie_after_rst_sum", res_sum, 8'h0B);

        // Drain to idle: the lone result is taken and nothing follows.
        for (int i = 0; i < 4; i++) begin
            step(0, 8'hEE, 8'hEE, 0, 8'hDD, 8'hDD, 1, 0, o0, o1, f0, f1);
            chk($sformatf("drain%0d_res_valid", i), res_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
